// File: rtl/dm_dump_serializer_pkg.sv
// ============================================================================
//  Module      : dm_dump_serializer_pkg
//  Description : Shared definitions for the data-memory dump serializer.
//                Holds the default address/data widths and the FSM state
//                encodings. The encodings also serve the interface block's
//                debug readout, so they must not be renumbered casually.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dm_dump_serializer_pkg;

    // Default geometry of the BIP data memory
    localparam int DM_ADDR_W = 12;
    localparam int DM_DATA_W = 16;   // exactly two bytes per word

    // FSM state encodings. TX_CK/W_CK are only reached when the checksum
    // byte is built in (DM_DUMP_CHECKSUM_EN).
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_RD    = 4'd1;
    localparam logic [3:0] S_LATCH = 4'd2;
    localparam logic [3:0] S_TX_LO = 4'd3;
    localparam logic [3:0] S_W_LO  = 4'd4;
    localparam logic [3:0] S_TX_HI = 4'd5;
    localparam logic [3:0] S_W_HI  = 4'd6;
    localparam logic [3:0] S_NEXT  = 4'd7;
    localparam logic [3:0] S_FIN   = 4'd8;
    localparam logic [3:0] S_TX_CK = 4'd9;
    localparam logic [3:0] S_W_CK  = 4'd10;

endpackage : dm_dump_serializer_pkg

`default_nettype wire

// File: rtl/dm_dump_serializer.sv
// ============================================================================
//  Module      : dm_dump_serializer
//  Description : Reads word_count 16-bit words from data memory starting at
//                base_addr and streams them to the UART transmitter, low byte
//                first, using a tx_start/tx_done handshake.
//
//  Build option: DM_DUMP_CHECKSUM_EN - when defined, one extra byte holding
//                the XOR of every byte sent in the dump is transmitted after
//                the last word (a lone 0x00 for an empty dump).
//
//  Ports       : clk, reset          clock, synchronous active-high reset
//                start               1-cycle pulse, accepted only when idle
//                base_addr           first word address (sampled on start)
//                word_count          words to dump (sampled on start)
//                RdDM, addr          data-memory read strobe and address
//                dm_data             read data, valid 1 cycle after RdDM
//                tx_start, d_out     byte handshake towards the UART
//                tx_done             UART byte-complete pulse
//                busy, done          dump in progress / completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_dump_serializer
    import dm_dump_serializer_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W   // fixed at 16: two bytes per word
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic              RdDM,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dm_data,
    output logic              tx_start,
    output logic [7:0]        d_out,
    input  logic              tx_done,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] C_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [3:0]        state_q,  state_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [ADDR_W-1:0] remain_q, remain_d;
    logic [DATA_W-1:0] word_q,   word_d;
    logic [7:0]        dout_q,   dout_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
`ifdef DM_DUMP_CHECKSUM_EN
    logic [7:0]        ck_q,     ck_d;
`endif

    // ------------------------------------------------------------------
    // Next-state logic. d_out is loaded on the transition INTO each TX_*
    // state so the byte is already valid in the cycle tx_start is high,
    // and it is left untouched until the matching tx_done.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        word_d   = word_q;
        dout_d   = dout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef DM_DUMP_CHECKSUM_EN
        ck_d     = ck_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = word_count;
                    busy_d   = 1'b1;
`ifdef DM_DUMP_CHECKSUM_EN
                    ck_d     = 8'h00;
                    if (word_count == '0) begin
                        // Empty dump still emits the (zero) checksum byte
                        dout_d  = 8'h00;
                        state_d = S_TX_CK;
                    end else begin
                        state_d = S_RD;
                    end
`else
                    state_d  = (word_count == '0) ? S_FIN : S_RD;
`endif
                end
            end

            S_RD: begin
                state_d = S_LATCH;
            end

            S_LATCH: begin
                // Memory data is valid in this cycle only
                word_d  = dm_data;
                dout_d  = dm_data[7:0];
`ifdef DM_DUMP_CHECKSUM_EN
                ck_d    = ck_q ^ dm_data[7:0];
`endif
                state_d = S_TX_LO;
            end

            S_TX_LO: begin
                // tx_done in this cycle belongs to no byte of ours; ignore it
                state_d = S_W_LO;
            end

            S_W_LO: begin
                if (tx_done) begin
                    dout_d  = word_q[15:8];
`ifdef DM_DUMP_CHECKSUM_EN
                    ck_d    = ck_q ^ word_q[15:8];
`endif
                    state_d = S_TX_HI;
                end
            end

            S_TX_HI: begin
                state_d = S_W_HI;
            end

            S_W_HI: begin
                if (tx_done) begin
                    state_d = S_NEXT;
                end
            end

            S_NEXT: begin
                addr_d   = addr_q + C_ONE;        // wraps at 2^ADDR_W
                remain_d = remain_q - C_ONE;
                if (remain_q == C_ONE) begin
`ifdef DM_DUMP_CHECKSUM_EN
                    dout_d  = ck_q;
                    state_d = S_TX_CK;
`else
                    state_d = S_FIN;
`endif
                end else begin
                    state_d = S_RD;
                end
            end

`ifdef DM_DUMP_CHECKSUM_EN
            S_TX_CK: begin
                state_d = S_W_CK;
            end

            S_W_CK: begin
                if (tx_done) begin
                    state_d = S_FIN;
                end
            end
`endif

            S_FIN: begin
                // done and the fall of busy appear together on the next cycle
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            word_q   <= '0;
            dout_q   <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef DM_DUMP_CHECKSUM_EN
            ck_q     <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            word_q   <= word_d;
            dout_q   <= dout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef DM_DUMP_CHECKSUM_EN
            ck_q     <= ck_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Strobes decode directly from state so each lasts exactly
    // one cycle and drops to 0 the cycle after reset.
    // ------------------------------------------------------------------
    assign RdDM  = (state_q == S_RD);
`ifdef DM_DUMP_CHECKSUM_EN
    assign tx_start = (state_q == S_TX_LO) || (state_q == S_TX_HI) ||
                      (state_q == S_TX_CK);
`else
    assign tx_start = (state_q == S_TX_LO) || (state_q == S_TX_HI);
`endif
    assign addr  = addr_q;
    assign d_out = dout_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule : dm_dump_serializer

`default_nettype wire

// File: tb/tb_dm_dump_serializer.sv
// ============================================================================
//  Module      : tb_dm_dump_serializer
//  Description : Scoreboard bench for dm_dump_serializer. The stimulus side
//                pushes expected read addresses, bytes and done events; a
//                monitor on the falling edge plays memory and UART and pops
//                and compares whatever the DUT presents.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_dump_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] base_addr;
    logic [11:0] word_count;
    logic        RdDM;
    logic [11:0] addr;
    logic [15:0] dm_data;
    logic        tx_start;
    logic [7:0]  d_out;
    logic        tx_done;
    logic        busy;
    logic        done;

    dm_dump_serializer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .RdDM       (RdDM),
        .addr       (addr),
        .dm_data    (dm_data),
        .tx_start   (tx_start),
        .d_out      (d_out),
        .tx_done    (tx_done),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] mem [4096];
    logic [11:0] exp_addr  [$];
    logic [7:0]  exp_bytes [$];
    int          exp_done  = 0;

    int  done_seen = 0;
    int  tx_count  = 0;
    int  first_rd  = -1;
    int  first_tx  = -1;
    int  done_cyc  = -1;
    int  start_cyc = 0;
    int  delay_min = 0;
    int  delay_max = 3;
    bit  spur_en   = 1'b1;

    bit          rd_prev  = 1'b0;
    logic [11:0] addr_prev;
    bit          waiting  = 1'b0;
    int          wcnt     = 0;
    logic [7:0]  hold;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: actual=%0h required=none (cycle %0d)", name, act, cyc);
    endtask

    // Reference model: the byte stream is simply each word of the address
    // range (modulo 4096) split low byte then high byte.
    task automatic push_dump(input logic [11:0] base, input int count);
        logic [7:0] ck;
        logic [11:0] a;
        ck = 8'h00;
        for (int i = 0; i < count; i++) begin
            a = 12'((int'(base) + i) % 4096);
            exp_addr.push_back(a);
            exp_bytes.push_back(mem[a][7:0]);
            exp_bytes.push_back(mem[a][15:8]);
            ck = ck ^ mem[a][7:0] ^ mem[a][15:8];
        end
`ifdef DM_DUMP_CHECKSUM_EN
        exp_bytes.push_back(ck);
`endif
        exp_done++;
    endtask

    // ------------------------------------------------------------------
    // Monitor / environment: memory, UART and scoreboard pops.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (reset) begin
            rd_prev = 1'b0;
            waiting = 1'b0;
            tx_done = 1'b0;
            dm_data = 16'($urandom);
        end else begin
            // Memory: data appears only in the cycle after the read strobe
            if (rd_prev) dm_data = mem[addr_prev];
            else         dm_data = 16'($urandom);
            rd_prev   = RdDM;
            addr_prev = addr;

            if (RdDM) begin
                if (first_rd < 0) first_rd = cyc;
                if (exp_addr.size() == 0) flag("rd_unexpected", 32'(addr));
                else check("rd_addr", 32'(addr), 32'(exp_addr.pop_front()));
            end

            // UART
            if (tx_start) begin
                tx_count++;
                if (first_tx < 0) first_tx = cyc;
                if (exp_bytes.size() == 0) flag("tx_unexpected", 32'(d_out));
                else check("byte", 32'(d_out), 32'(exp_bytes.pop_front()));
                hold    = d_out;
                waiting = 1'b1;
                wcnt    = $urandom_range(delay_max, delay_min);
                // A tx_done coincident with tx_start must be ignored
                tx_done = spur_en && ($urandom_range(1, 0) == 1);
            end else if (waiting) begin
                check("d_out_stable", 32'(d_out), 32'(hold));
                if (wcnt == 0) begin
                    tx_done = 1'b1;
                    waiting = 1'b0;
                end else begin
                    wcnt--;
                    tx_done = 1'b0;
                end
            end else begin
                tx_done = spur_en && ($urandom_range(3, 0) == 0);
            end

            if (done) begin
                done_seen++;
                done_cyc = cyc;
                if (exp_done == 0) flag("done_unexpected", 32'(done_seen));
                else begin
                    exp_done--;
                    check("busy_at_done", 32'(busy), 32'h0);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Issue one dump and wait (bounded) for its done pulse.
    task automatic run_dump(input logic [11:0] base, input int count, input int repulse_at);
        int seen0, tx0, bound;
        bit ok;
        push_dump(base, count);
        seen0 = done_seen;
        tx0   = tx_count;
        first_rd = -1;
        first_tx = -1;
        done_cyc = -1;
        base_addr  = base;
        word_count = 12'(count);
        start      = 1'b1;
        start_cyc  = cyc;
        step();
        start      = 1'b0;
        base_addr  = 12'($urandom);
        word_count = 12'($urandom);
        bound = 40 + (count + 1) * 2 * (delay_max + 10);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (i == repulse_at) start = 1'b1;   // must be ignored while busy
            step();
            start = 1'b0;
            if (done_seen != seen0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flag("done_timeout", 32'(count));
        check("addr_left",  32'(exp_addr.size()), 32'h0);
        check("bytes_left", 32'(exp_bytes.size()), 32'h0);
`ifdef DM_DUMP_CHECKSUM_EN
        check("tx_pulses", 32'(tx_count - tx0), 32'(2 * count + 1));
`else
        check("tx_pulses", 32'(tx_count - tx0), 32'(2 * count));
`endif
        step();
        step();
    endtask

    initial begin
        int seen0;
        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        tx_done    = 1'b0;
        dm_data    = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);

        // 1. reset state, then a single word
        step();
        step();
        check("rst_RdDM",     32'(RdDM),     32'h0);
        check("rst_addr",     32'(addr),     32'h0);
        check("rst_tx_start", 32'(tx_start), 32'h0);
        check("rst_d_out",    32'(d_out),    32'h0);
        check("rst_busy",     32'(busy),     32'h0);
        check("rst_done",     32'(done),     32'h0);
        reset = 1'b0;
        step();

        mem[12'h010] = 16'hBEEF;
        run_dump(12'h010, 1, -1);
        check("lat_first_rd", 32'(first_rd), 32'(start_cyc + 1));
        check("lat_first_tx", 32'(first_tx), 32'(start_cyc + 3));
        check("busy_after",   32'(busy),     32'h0);

        // 2. address wrap
        mem[12'hFFE] = 16'h1122;
        mem[12'hFFF] = 16'h3344;
        mem[12'h000] = 16'h5566;
        run_dump(12'hFFE, 3, -1);

        // 3. empty dump
        run_dump(12'h123, 0, -1);
        check("empty_no_rd", 32'(first_rd), 32'hFFFF_FFFF);
`ifndef DM_DUMP_CHECKSUM_EN
        check("empty_no_tx",   32'(first_tx), 32'hFFFF_FFFF);
        check("empty_done_at", 32'(done_cyc), 32'(start_cyc + 2));
`endif

        // 4. slow UART, spurious tx_done, start re-pulsed mid-dump
        delay_min = 50;
        delay_max = 50;
        run_dump(12'h200, 3, 20);
        delay_min = 0;
        delay_max = 3;

        // 5. reset in W_HI of word 2 of 4
        delay_min = 5;
        delay_max = 8;
        push_dump(12'h300, 4);
        seen0 = done_seen;
        tx_count = 0;
        base_addr  = 12'h300;
        word_count = 12'd4;
        start      = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 200 && tx_count < 4; i++) step();
        check("tx_before_reset", 32'(tx_count), 32'd4);
        step();                         // DUT now waiting in W_HI
        reset = 1'b1;
        step();
        check("mid_rst_RdDM",     32'(RdDM),     32'h0);
        check("mid_rst_addr",     32'(addr),     32'h0);
        check("mid_rst_tx_start", 32'(tx_start), 32'h0);
        check("mid_rst_d_out",    32'(d_out),    32'h0);
        check("mid_rst_busy",     32'(busy),     32'h0);
        exp_addr.delete();
        exp_bytes.delete();
        exp_done = 0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("no_done_after_rst", 32'(done_seen), 32'(seen0));
        delay_min = 0;
        delay_max = 3;
        run_dump(12'h300, 4, 5);

`ifdef DM_DUMP_CHECKSUM_EN
        // 6. checksum example
        mem[12'h400] = 16'hBEEF;
        mem[12'h401] = 16'h0102;
        run_dump(12'h400, 2, -1);
`endif

        // Randomized dumps
        for (int n = 0; n < 15; n++) begin
            int cnt, rp;
            cnt = $urandom_range(6, 0);
            rp  = ($urandom_range(2, 0) == 0) ? int'($urandom_range(15, 1)) : -1;
            delay_max = $urandom_range(4, 0);
            run_dump(12'($urandom), cnt, rp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dm_dump_serializer

`default_nettype wire
